uart_cmd_parser: RTL and testbench
==================================

Name: uart_cmd_parser

Overview:
- Sits directly behind the UART receiver in the audio FFT/FIR design.
- Turns the receiver's byte stream into validated configuration-register writes, e.g. FIR coefficient select, FFT enable or audio gain.
- Frames bytes, checks a header and checksum, and enforces an inter-byte timeout.
- Issues one write per good frame on a req/ack configuration port shared with the downstream register file.

Parameters:
- TIMEOUT_CYC, 100000, clk cycles allowed between consecutive bytes of one frame (2 ms at 50 MHz).
- HDR0, 8'h55, first header byte.
- HDR1, 8'hAA, second header byte.

Ports:
- clk  in  1  system clock, same domain as the UART receiver
- rst  in  1  asynchronous, active-high reset
- rx_data  in  8  received byte; valid while rx_en is high
- rx_en  in  1  receiver byte-valid LEVEL; stays high for several cycles per byte
- cfg_wr_req  out  1  write request; held until acknowledged
- cfg_addr  out  8  register address
- cfg_wdata  out  16  register data
- cfg_wr_ack  in  1  single-cycle acknowledge from the register file
- frame_ok  out  1  one-cycle pulse when a write completes (ack seen)
- frame_err  out  1  one-cycle pulse on any frame error
- err_code  out  2  cause of last error: 0 bad header, 1 checksum, 2 timeout, 3 overrun; holds until the next error
- frame_cnt  out  8  count of good frames, wraps 255->0

Behaviour:
- Reset: all outputs 0, state IDLE, timeout counter 0, internal rx_en delay register 0.
- Byte strobe: byte_stb = rx_en & ~rx_en_d (registered rising edge); rx_data is sampled on that cycle. Exactly one strobe per received byte.
- Frame format: HDR0, HDR1, ADDR, DH, DL, CKS, where CKS = (ADDR+DH+DL) mod 256 (8-bit wrap sum).
- States, each transition taken on byte_stb unless noted:
  - IDLE: byte==HDR0 -> H1; any other byte is ignored silently.
  - H1: HDR1 -> ADR; HDR0 -> stay in H1 (resync); else frame_err, code 0, -> IDLE.
  - ADR: latch addr, sum=byte -> DH.
  - DH: latch data[15:8], sum+=byte -> DL.
  - DL: latch data[7:0], sum+=byte -> CK.
  - CK: byte==sum -> WR, with cfg_wr_req=1 and cfg_addr/cfg_wdata driven from the latches on the next cycle; else frame_err, code 1, -> IDLE.
  - WR: hold req, addr and data stable until cfg_wr_ack. On ack: req=0 next cycle, frame_ok pulse, frame_cnt+1, -> IDLE.
- Ack in the same cycle req first rises is legal and completes the write.
- Timeout counter: cleared on every byte_stb and whenever in IDLE or WR; increments otherwise. On reaching TIMEOUT_CYC-1: frame_err, code 2, -> IDLE.
- byte_stb arriving on the same cycle as timeout expiry: timeout wins and the byte is dropped.
- byte_stb while in WR: byte dropped, frame_err pulse, code 3. The pending write still completes; the parser does not resync mid-write.
- cfg_wr_ack outside WR is ignored.
- Reset asserted mid-frame or mid-write: immediate return to reset values; cfg_wr_req drops asynchronously.
- frame_ok and frame_err are never asserted in the same cycle.

Decomposition:
- Shared package uart_cmd_pkg holds:
  - state encoding localparams (IDLE, H1, ADR, DH, DL, CK, WR);
  - err_code localparams (ERR_HDR, ERR_CKS, ERR_TMO, ERR_OVR);
  - default header constants.
- One natural sub-module, uart_byte_timeout: a loadable down-counter with clear and expire outputs, parameterised by TIMEOUT_CYC.
- Edge detection and the FSM stay in the top module.

Test Plan:
- Good frame: send 55 AA 10 12 34 56 (sum 0x56), ack 3 cycles after req -> req held with addr=0x10, wdata=0x1234; then one frame_ok pulse, frame_cnt=1.
- Checksum error: send 55 AA 10 12 34 57 -> frame_err, err_code=1, no cfg_wr_req; the following good frame is then accepted.
- Resync and bad header:
  - 55 55 AA 01 00 02 03 -> write addr 0x01, wdata 0x0002.
  - 55 3C -> frame_err, err_code=0.
- Timeout: send 55 AA 10 then idle for TIMEOUT_CYC cycles (use TIMEOUT_CYC=64 in the bench) -> frame_err, err_code=2, state IDLE; the next full frame is accepted.
- Overrun and level strobe:
  - Hold ack low and send an extra byte while in WR -> frame_err, err_code=3; the original write still completes with its data unchanged.
  - Hold rx_en high for 500 cycles -> only one byte is counted.
- Async reset mid-write, then counter wrap:
  - Assert rst while cfg_wr_req=1 -> req=0 without waiting for a clock edge; frame_cnt=0.
  - Send 256 good frames -> frame_cnt wraps to 0.

Source files
------------

// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the UART command parser.
package uart_cmd_pkg;

  // Frame-parser states: header bytes, address, data high/low, checksum, write.
  typedef enum logic [2:0] {
    IDLE,
    H1,
    ADR,
    DH,
    DL,
    CK,
    WR
  } state_t;

  // Values reported on err_code.
  typedef enum logic [1:0] {
    ERR_HDR = 2'd0,
    ERR_CKS = 2'd1,
    ERR_TMO = 2'd2,
    ERR_OVR = 2'd3
  } err_t;

  localparam logic [7:0] HDR0_DEFAULT = 8'h55;
  localparam logic [7:0] HDR1_DEFAULT = 8'hAA;

endpackage

// File: rtl/uart_byte_timeout.sv
// Inter-byte timeout: a down-counter reloaded by clr, expire when it reaches zero.
module uart_byte_timeout #(
  parameter int unsigned TIMEOUT_CYC = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic expire
);

  localparam int unsigned CW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0] LOAD = CW'(TIMEOUT_CYC - 1);

  // Holds cycles remaining rather than cycles elapsed, so the reset/clear value
  // LOAD corresponds to an elapsed count of zero; expiry is at elapsed TIMEOUT_CYC-1.
  logic [CW-1:0] cnt_q, cnt_d;

  // Reload on clear, otherwise count down and saturate at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = LOAD;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= LOAD;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = (cnt_q == '0);

endmodule

// File: rtl/uart_cmd_parser.sv
// Frames UART bytes into checked configuration writes on a req/ack port.
module uart_cmd_parser
  import uart_cmd_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 100000,
  parameter logic [7:0]  HDR0        = HDR0_DEFAULT,
  parameter logic [7:0]  HDR1        = HDR1_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_en,
  output logic        cfg_wr_req,
  output logic [7:0]  cfg_addr,
  output logic [15:0] cfg_wdata,
  input  logic        cfg_wr_ack,
  output logic        frame_ok,
  output logic        frame_err,
  output logic [1:0]  err_code,
  output logic [7:0]  frame_cnt
);

  state_t      state_q, state_d;
  logic        rx_en_d_q;
  logic [7:0]  addr_q, addr_d;
  logic [15:0] data_q, data_d;
  logic [7:0]  sum_q, sum_d;
  logic        req_q, req_d;
  logic [7:0]  cfg_addr_q, cfg_addr_d;
  logic [15:0] cfg_wdata_q, cfg_wdata_d;
  logic        frame_ok_q, frame_ok_d;
  logic        frame_err_q, frame_err_d;
  logic [1:0]  err_code_q, err_code_d;
  logic [7:0]  frame_cnt_q, frame_cnt_d;
  logic        ovr_pend_q, ovr_pend_d;

  logic byte_stb;
  logic tmo_clr;
  logic tmo_expire;
  logic tmo_hit;
  logic in_frame;

  assign byte_stb = rx_en & ~rx_en_d_q;
  assign in_frame = (state_q == H1) || (state_q == ADR) || (state_q == DH) ||
                    (state_q == DL) || (state_q == CK);
  assign tmo_clr  = byte_stb | (state_q == IDLE) | (state_q == WR);
  assign tmo_hit  = in_frame & tmo_expire;

  uart_byte_timeout #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timeout (
    .clk   (clk),
    .rst   (rst),
    .clr   (tmo_clr),
    .expire(tmo_expire)
  );

  // Next-state and output logic; timeout takes priority over a same-cycle byte.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    data_d      = data_q;
    sum_d       = sum_q;
    req_d       = req_q;
    cfg_addr_d  = cfg_addr_q;
    cfg_wdata_d = cfg_wdata_q;
    frame_ok_d  = 1'b0;
    frame_err_d = 1'b0;
    err_code_d  = err_code_q;
    frame_cnt_d = frame_cnt_q;
    ovr_pend_d  = 1'b0;

    // A byte that collided with the completing ack is reported one cycle
    // later so frame_ok and frame_err never pulse together.
    if (ovr_pend_q) begin
      frame_err_d = 1'b1;
      err_code_d  = ERR_OVR;
    end

    if (tmo_hit) begin
      state_d     = IDLE;
      frame_err_d = 1'b1;
      err_code_d  = ERR_TMO;
    end else begin
      case (state_q)
        IDLE: begin
          if (byte_stb && rx_data == HDR0) state_d = H1;
        end
        H1: begin
          if (byte_stb) begin
            if (rx_data == HDR1) begin
              state_d = ADR;
            end else if (rx_data != HDR0) begin
              state_d     = IDLE;
              frame_err_d = 1'b1;
              err_code_d  = ERR_HDR;
            end
          end
        end
        ADR: begin
          if (byte_stb) begin
            addr_d  = rx_data;
            sum_d   = rx_data;
            state_d = DH;
          end
        end
        DH: begin
          if (byte_stb) begin
            data_d[15:8] = rx_data;
            sum_d        = sum_q + rx_data;
            state_d      = DL;
          end
        end
        DL: begin
          if (byte_stb) begin
            data_d[7:0] = rx_data;
            sum_d       = sum_q + rx_data;
            state_d     = CK;
          end
        end
        CK: begin
          if (byte_stb) begin
            if (rx_data == sum_q) begin
              state_d     = WR;
              req_d       = 1'b1;
              cfg_addr_d  = addr_q;
              cfg_wdata_d = data_q;
            end else begin
              state_d     = IDLE;
              frame_err_d = 1'b1;
              err_code_d  = ERR_CKS;
            end
          end
        end
        WR: begin
          if (cfg_wr_ack) begin
            req_d       = 1'b0;
            frame_ok_d  = 1'b1;
            frame_cnt_d = frame_cnt_q + 8'd1;
            state_d     = IDLE;
            ovr_pend_d  = byte_stb;
          end else if (byte_stb) begin
            frame_err_d = 1'b1;
            err_code_d  = ERR_OVR;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      rx_en_d_q   <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      sum_q       <= '0;
      req_q       <= 1'b0;
      cfg_addr_q  <= '0;
      cfg_wdata_q <= '0;
      frame_ok_q  <= 1'b0;
      frame_err_q <= 1'b0;
      err_code_q  <= '0;
      frame_cnt_q <= '0;
      ovr_pend_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      rx_en_d_q   <= rx_en;
      addr_q      <= addr_d;
      data_q      <= data_d;
      sum_q       <= sum_d;
      req_q       <= req_d;
      cfg_addr_q  <= cfg_addr_d;
      cfg_wdata_q <= cfg_wdata_d;
      frame_ok_q  <= frame_ok_d;
      frame_err_q <= frame_err_d;
      err_code_q  <= err_code_d;
      frame_cnt_q <= frame_cnt_d;
      ovr_pend_q  <= ovr_pend_d;
    end
  end

  assign cfg_wr_req = req_q;
  assign cfg_addr   = cfg_addr_q;
  assign cfg_wdata  = cfg_wdata_q;
  assign frame_ok   = frame_ok_q;
  assign frame_err  = frame_err_q;
  assign err_code   = err_code_q;
  assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed bench for uart_cmd_parser with a write scoreboard.
module tb_uart_cmd_parser;

  localparam int unsigned TMO = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data = '0;
  logic        rx_en = 1'b0;
  logic        cfg_wr_req;
  logic [7:0]  cfg_addr;
  logic [15:0] cfg_wdata;
  logic        cfg_wr_ack = 1'b0;
  logic        frame_ok;
  logic        frame_err;
  logic [1:0]  err_code;
  logic [7:0]  frame_cnt;

  typedef struct packed {
    logic [7:0]  addr;
    logic [15:0] data;
  } wr_t;

  wr_t         exp_q[$];
  logic [7:0]  exp_cnt = '0;
  int unsigned n_checks = 0;
  int unsigned n_pass = 0;
  int unsigned n_fail = 0;
  int unsigned err_pulses = 0;
  int unsigned ok_pulses = 0;
  int unsigned both_pulses = 0;

  always #5 clk = ~clk;

  uart_cmd_parser #(
    .TIMEOUT_CYC(TMO),
    .HDR0       (8'h55),
    .HDR1       (8'hAA)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_data   (rx_data),
    .rx_en     (rx_en),
    .cfg_wr_req(cfg_wr_req),
    .cfg_addr  (cfg_addr),
    .cfg_wdata (cfg_wdata),
    .cfg_wr_ack(cfg_wr_ack),
    .frame_ok  (frame_ok),
    .frame_err (frame_err),
    .err_code  (err_code),
    .frame_cnt (frame_cnt)
  );

  // Pulse counters, sampled shortly after each active edge.
  always @(posedge clk) begin
    #1;
    if (frame_err === 1'b1) err_pulses++;
    if (frame_ok === 1'b1) ok_pulses++;
    if (frame_ok === 1'b1 && frame_err === 1'b1) both_pulses++;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] cks(input logic [7:0] a, input logic [7:0] dh, input logic [7:0] dl);
    logic [7:0] s;
    s = a + dh;
    s = s + dl;
    return s;
  endfunction

  task automatic send_byte(input logic [7:0] b, input int hold = 3);
    @(negedge clk);
    rx_data = b;
    rx_en   = 1'b1;
    repeat (hold) @(negedge clk);
    rx_en = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] a, input logic [7:0] dh, input logic [7:0] dl,
                            input logic [7:0] ck);
    send_byte(8'h55);
    send_byte(8'hAA);
    send_byte(a);
    send_byte(dh);
    send_byte(dl);
    send_byte(ck);
  endtask

  task automatic push_exp(input logic [7:0] a, input logic [15:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic good_frame(input logic [7:0] a, input logic [15:0] d);
    push_exp(a, d);
    send_frame(a, d[15:8], d[7:0], cks(a, d[15:8], d[7:0]));
  endtask

  // Wait (bounded) for a request, compare against the scoreboard, ack after a delay.
  task automatic complete_write(input int ack_delay);
    wr_t e;
    int  w;
    w = 0;
    while (cfg_wr_req !== 1'b1 && w < 50) begin
      @(negedge clk);
      w++;
    end
    check("req_seen", 32'(cfg_wr_req), 32'd1);
    check("sb_pending", exp_q.size(), 32'd1);
    e = '0;
    if (exp_q.size() > 0) e = exp_q.pop_front();
    check("wr_addr", 32'(cfg_addr), 32'(e.addr));
    check("wr_data", 32'(cfg_wdata), 32'(e.data));
    repeat (ack_delay) @(negedge clk);
    if (ack_delay > 0) begin
      check("req_held", 32'(cfg_wr_req), 32'd1);
      check("wr_data_held", 32'({cfg_addr, cfg_wdata}), 32'({e.addr, e.data}));
    end
    cfg_wr_ack = 1'b1;
    @(negedge clk);
    cfg_wr_ack = 1'b0;
    exp_cnt = exp_cnt + 8'd1;
    check("req_drop", 32'(cfg_wr_req), 32'd0);
    check("frame_ok_pulse", 32'(frame_ok), 32'd1);
    check("frame_cnt", 32'(frame_cnt), 32'(exp_cnt));
    @(negedge clk);
    check("frame_ok_single", 32'(frame_ok), 32'd0);
  endtask

  initial begin
    int unsigned e0;
    int          w;
    wr_t         e;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_req", 32'(cfg_wr_req), 32'd0);
    check("rst_outs", 32'({frame_ok, frame_err, err_code, frame_cnt}), 32'd0);
    check("rst_bus", 32'({cfg_addr, cfg_wdata}), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Good frame, ack 3 cycles after request
    e0 = err_pulses;
    good_frame(8'h10, 16'h1234);
    complete_write(3);
    check("good_no_err", err_pulses - e0, 32'd0);

    // Checksum error, then a good frame
    e0 = err_pulses;
    send_frame(8'h10, 8'h12, 8'h34, 8'h57);
    check("cks_err", err_pulses - e0, 32'd1);
    check("cks_code", 32'(err_code), 32'd1);
    check("cks_no_req", 32'(cfg_wr_req), 32'd0);
    good_frame(8'h42, 16'hBEEF);
    complete_write(1);

    // Resync on repeated HDR0
    e0 = err_pulses;
    push_exp(8'h01, 16'h0002);
    send_byte(8'h55);
    send_byte(8'h55);
    send_byte(8'hAA);
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h02);
    send_byte(8'h03);
    complete_write(0);
    check("resync_no_err", err_pulses - e0, 32'd0);

    // Bad second header byte
    e0 = err_pulses;
    send_byte(8'h55);
    send_byte(8'h3C);
    check("hdr_err", err_pulses - e0, 32'd1);
    check("hdr_code", 32'(err_code), 32'd0);

    // Inter-byte timeout after the address byte
    e0 = err_pulses;
    send_byte(8'h55);
    send_byte(8'hAA);
    send_byte(8'h10);
    repeat (50) @(negedge clk);
    check("tmo_not_early", err_pulses - e0, 32'd0);
    w = 0;
    while (err_pulses == e0 && w < 40) begin
      @(negedge clk);
      w++;
    end
    check("tmo_err", err_pulses - e0, 32'd1);
    check("tmo_code", 32'(err_code), 32'd2);
    check("tmo_no_req", 32'(cfg_wr_req), 32'd0);
    good_frame(8'h20, 16'h0102);
    complete_write(2);

    // Ack outside a write is ignored
    e0 = ok_pulses;
    @(negedge clk);
    cfg_wr_ack = 1'b1;
    @(negedge clk);
    cfg_wr_ack = 1'b0;
    repeat (2) @(negedge clk);
    check("stray_ack_ok", ok_pulses - e0, 32'd0);
    check("stray_ack_cnt", 32'(frame_cnt), 32'(exp_cnt));

    // Overrun while waiting for ack; level held 500 cycles yields one byte
    good_frame(8'h33, 16'hA5C3);
    e0 = err_pulses;
    send_byte(8'h77, 500);
    check("ovr_err_once", err_pulses - e0, 32'd1);
    check("ovr_code", 32'(err_code), 32'd3);
    check("ovr_req_held", 32'(cfg_wr_req), 32'd1);
    complete_write(0);

    // Ack in the first cycle of the request
    push_exp(8'h7E, 16'h0001);
    send_byte(8'h55);
    send_byte(8'hAA);
    send_byte(8'h7E);
    send_byte(8'h00);
    send_byte(8'h01);
    @(negedge clk);
    rx_data = cks(8'h7E, 8'h00, 8'h01);
    rx_en   = 1'b1;
    @(negedge clk);
    check("early_req", 32'(cfg_wr_req), 32'd1);
    e = '0;
    if (exp_q.size() > 0) e = exp_q.pop_front();
    check("early_wr", 32'({cfg_addr, cfg_wdata}), 32'({e.addr, e.data}));
    cfg_wr_ack = 1'b1;
    @(negedge clk);
    cfg_wr_ack = 1'b0;
    exp_cnt = exp_cnt + 8'd1;
    check("early_req_drop", 32'(cfg_wr_req), 32'd0);
    check("early_ok", 32'(frame_ok), 32'd1);
    check("early_cnt", 32'(frame_cnt), 32'(exp_cnt));
    rx_en = 1'b0;
    repeat (2) @(negedge clk);

    // Asynchronous reset during a pending write
    good_frame(8'h5A, 16'hC0DE);
    check("pre_rst_req", 32'(cfg_wr_req), 32'd1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_req", 32'(cfg_wr_req), 32'd0);
    check("async_cnt", 32'(frame_cnt), 32'd0);
    check("async_code", 32'(err_code), 32'd0);
    exp_q.delete();
    exp_cnt = '0;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // 256 good frames wrap frame_cnt back to zero
    for (int i = 0; i < 256; i++) begin
      logic [7:0] a;
      a = 8'(i);
      good_frame(a, {~a, 8'(i * 3)});
      complete_write(0);
    end
    check("wrap_cnt", 32'(frame_cnt), 32'd0);
    check("never_ok_and_err", both_pulses, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
